// File: rtl/demux_1to2_l2.sv
// Splits an alternating word stream into two show-ahead lane FIFOs.
// A word that finds its lane full is dropped and sets the sticky overflow flag.
module demux_1to2_l2 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             pop0,
    input  logic             pop1,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             full0,
    output logic             full1,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic             sel;
    logic [WIDTH-1:0] mem     [2][DEPTH];
    logic [AW-1:0]    wr_ptr  [2];
    logic [AW-1:0]    rd_ptr  [2];
    logic [CW-1:0]    count   [2];

    logic [1:0] pop_req;
    logic [1:0] push;
    logic [1:0] pop_ok;
    logic [1:0] wr_ok;
    logic [1:0] lane_full;
    logic [1:0] lane_valid;
    logic       drop;

    assign pop_req = {pop1, pop0};

    always_comb begin
        drop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lane_valid[i] = (count[i] != '0);
            lane_full[i]  = (count[i] == FULL_CNT);
            push[i]       = valid_in && (sel == 1'(i));
            pop_ok[i]     = pop_req[i] && lane_valid[i];
            // A pop in the same cycle frees the slot, so a full lane still accepts.
            wr_ok[i]      = push[i] && (!lane_full[i] || pop_ok[i]);
            drop          = drop || (push[i] && !wr_ok[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel      <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            // Toggle even on a dropped word to keep lane alignment.
            if (valid_in) sel <= ~sel;
            if (drop)     overflow <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (wr_ok[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_ok[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (wr_ok[i] && !pop_ok[i])      count[i] <= count[i] + 1'b1;
                else if (!wr_ok[i] && pop_ok[i]) count[i] <= count[i] - 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; empty lanes mask it to zero at the outputs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_ok[i]) mem[i][wr_ptr[i]] <= data_in;
        end
    end

    assign valid_out0 = lane_valid[0];
    assign valid_out1 = lane_valid[1];
    assign full0      = lane_full[0];
    assign full1      = lane_full[1];
    assign data_out0  = lane_valid[0] ? mem[0][rd_ptr[0]] : '0;
    assign data_out1  = lane_valid[1] ? mem[1][rd_ptr[1]] : '0;

endmodule

// File: tb/tb_demux_1to2_l2.sv
// Directed self-checking bench for demux_1to2_l2 (WIDTH=8, DEPTH=4).
module tb_demux_1to2_l2;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       pop0;
    logic       pop1;
    logic [7:0] data_out0;
    logic [7:0] data_out1;
    logic       valid_out0;
    logic       valid_out1;
    logic       full0;
    logic       full1;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    demux_1to2_l2 #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .pop0       (pop0),
        .pop1       (pop1),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .full0      (full0),
        .full1      (full1),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic p0, input logic p1);
        valid_in = v;
        data_in  = d;
        pop0     = p0;
        pop1     = p1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        pop0     = 1'b0;
        pop1     = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_v0"},  32'(valid_out0), 32'h0);
        check({tag, "_v1"},  32'(valid_out1), 32'h0);
        check({tag, "_d0"},  32'(data_out0),  32'h0);
        check({tag, "_d1"},  32'(data_out1),  32'h0);
        check({tag, "_f0"},  32'(full0),      32'h0);
        check({tag, "_f1"},  32'(full1),      32'h0);
        check({tag, "_ovf"}, 32'(overflow),   32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        check_idle("rst");
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        pop0     = 1'b0;
        pop1     = 1'b0;
        #12;
        check_idle("por");
        @(negedge clk);
        reset_L = 1'b1;

        // Basic split
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        cyc(1, 8'h0A, 0, 0);
        cyc(1, 8'h0B, 0, 0);
        check("split_d0", 32'(data_out0), 32'h01);
        check("split_d1", 32'(data_out1), 32'h02);
        check("split_v0", 32'(valid_out0), 32'h1);
        check("split_v1", 32'(valid_out1), 32'h1);
        check("split_f0", 32'(full0), 32'h0);
        cyc(0, 8'h00, 1, 1);
        check("split_pop_d0", 32'(data_out0), 32'h0A);
        check("split_pop_d1", 32'(data_out1), 32'h0B);
        cyc(0, 8'h00, 1, 1);
        check_idle("split_empty");

        // Gaps: idle cycles must not advance the selector
        cyc(1, 8'h05, 0, 0);
        check("gap_d0", 32'(data_out0), 32'h05);
        check("gap_v1", 32'(valid_out1), 32'h0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h06, 0, 0);
        check("gap_d1", 32'(data_out1), 32'h06);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'hFF, 0, 0);
        cyc(1, 8'hAA, 0, 0);
        check("gap_head0", 32'(data_out0), 32'h05);
        check("gap_head1", 32'(data_out1), 32'h06);
        cyc(0, 8'h00, 1, 1);
        check("gap_d0b", 32'(data_out0), 32'hFF);
        check("gap_d1b", 32'(data_out1), 32'hAA);
        cyc(0, 8'h00, 1, 1);
        check_idle("gap_empty");

        // Overflow: 10 words into two 4-deep lanes
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0, 0);
        check("ovf_f0", 32'(full0), 32'h1);
        check("ovf_f1", 32'(full1), 32'h1);
        check("ovf_pre", 32'(overflow), 32'h0);
        cyc(1, 8'h08, 0, 0);
        check("ovf_set", 32'(overflow), 32'h1);
        cyc(1, 8'h09, 0, 0);
        check("ovf_hold", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_d0", 32'(data_out0), 32'(2 * i));
            check("ovf_drain_d1", 32'(data_out1), 32'(2 * i + 1));
            cyc(0, 8'h00, 1, 1);
        end
        check("ovf_empty_v0", 32'(valid_out0), 32'h0);
        check("ovf_empty_v1", 32'(valid_out1), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);
        // Selector back at lane 0 after an even word count, drops included
        cyc(1, 8'h33, 0, 0);
        check("ovf_sel_d0", 32'(data_out0), 32'h33);
        check("ovf_sel_v1", 32'(valid_out1), 32'h0);

        // Simultaneous events
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 8'hA0 + 8'(i), 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1);
        check("ind_d0", 32'(data_out0), 32'hA0);
        check("ind_f0", 32'(full0), 32'h1);
        check("ind_v1", 32'(valid_out1), 32'h0);
        cyc(1, 8'hF1, 1, 0);
        check("pp_full_f0", 32'(full0), 32'h1);
        check("pp_full_d0", 32'(data_out0), 32'hA2);
        check("pp_full_ovf", 32'(overflow), 32'h0);
        cyc(0, 8'h00, 0, 1);
        check("pop_empty_v1", 32'(valid_out1), 32'h0);
        check("pop_empty_d1", 32'(data_out1), 32'h00);
        cyc(1, 8'h5C, 0, 1);
        check("pp_empty_d1", 32'(data_out1), 32'h5C);
        check("pp_empty_v1", 32'(valid_out1), 32'h1);
        cyc(0, 8'h00, 1, 0);
        check("tail_d0a", 32'(data_out0), 32'hA4);
        cyc(0, 8'h00, 1, 0);
        check("tail_d0b", 32'(data_out0), 32'hA6);
        cyc(0, 8'h00, 1, 0);
        check("tail_d0c", 32'(data_out0), 32'hF1);
        check("tail_d1", 32'(data_out1), 32'h5C);
        cyc(0, 8'h00, 1, 0);
        check("tail_v0", 32'(valid_out0), 32'h0);
        check("tail_ovf", 32'(overflow), 32'h0);

        // Reset mid-operation, asserted between edges
        do_reset();
        cyc(1, 8'h09, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        check("mid_d0", 32'(data_out0), 32'h09);
        check("mid_d1", 32'(data_out1), 32'hA2);
        #2;
        reset_L = 1'b0;
        #1;
        check_idle("mid_rst");
        #1;
        reset_L = 1'b1;
        cyc(1, 8'h01, 0, 0);
        check("mid_after_d0", 32'(data_out0), 32'h01);
        check("mid_after_v1", 32'(valid_out1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
